wb_cmd_master: RTL and testbench

Single-outstanding Wishbone classic initiator that turns a valid/ready command (read or write, address, data, byte select) into one Wishbone bus cycle and returns the read data and error status on a valid/ready response channel. It sits between the SPI command decoder and the Wishbone interconnect. Peripherals such as the version register are reached through this block. A built-in ack timeout guarantees that the block never hangs on an unmapped address.

---
 rtl/wb_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// ============================================================================
// wb_cmd_master : single-outstanding Wishbone classic initiator with
//                 valid/ready command/response channels and ack timeout.
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                done;

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready comes up one edge after reset release
        rdy_d = 1'b1;
        if (cmd_valid_i && rdy_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_err_i) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          done      = 1'b1;
        end else if (wb_ack_i) begin
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? '0 : wb_dat_i;
          done      = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          done      = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rdy_d       = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
// tb_wb_cmd_master : randomized self-checking bench for wb_cmd_master with a
//                    configurable Wishbone slave and a memory reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;

  localparam int TO = 16;
  localparam int M_ACK = 0, M_ERR = 1, M_ERRACK = 2, M_NONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] wb_adr, wb_dato, wb_dati;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, busy;
  logic [3:0]  wb_sel;

  int cmp = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dato), .wb_dat_i(wb_dati), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .busy_o(busy)
  );

  // ---------------- slave: answers after s_lat cycles of stb ----------------
  int          s_mode = M_ACK;
  int          s_lat  = 1;
  logic [7:0]  s_cnt;
  logic [31:0] s_mem [256];
  logic        s_hit;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial for (int i = 0; i < 256; i++) s_mem[i] = init_val(32'(i * 4));

  assign s_hit   = wb_stb && (s_cnt == s_lat[7:0]) && (s_mode != M_NONE);
  assign wb_ack  = s_hit && (s_mode == M_ACK || s_mode == M_ERRACK);
  assign wb_err  = s_hit && (s_mode == M_ERR || s_mode == M_ERRACK);
  assign wb_dati = s_mem[wb_adr[9:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) s_cnt <= '0;
    else if (!wb_stb) s_cnt <= '0;
    else s_cnt <= s_cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (s_hit) begin
      cap_adr <= wb_adr; cap_dat <= wb_dato; cap_we <= wb_we; cap_sel <= wb_sel;
      if (wb_ack && !wb_err && wb_we)
        s_mem[wb_adr[9:2]] <= merge(s_mem[wb_adr[9:2]], wb_dato, wb_sel);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Drives one command with rsp_ready already high; returns observations.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode, input int lat,
                        output int stb_n, output logic [31:0] rdat, output logic rerr,
                        output bit ok);
    int w;
    ok = 1'b1; stb_n = 0; rdat = '0; rerr = 1'b0;
    @(negedge clk);
    s_mode = mode; s_lat = lat;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!cmd_ready) begin ok = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 100) begin
      if (wb_stb) stb_n++;
      @(negedge clk); w++;
    end
    if (!rsp_valid) begin ok = 1'b0; rsp_ready = 1'b0; return; end
    rdat = rsp_dat; rerr = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- feature tests ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dato, wb_sel, rsp_valid, rsp_dat, rsp_err,
         cmd_ready, busy} !== '0) begin
      errs++; $display("FAIL reset_outputs: some output nonzero, cyc=%b rdy=%b adr=%h rv=%b",
                       wb_cyc, cmd_ready, wb_adr, rsp_valid);
    end
    rst = 1'b0;
    #1;
    cmp++;
    if (cmd_ready !== 1'b0) begin errs++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
    @(negedge clk);
    cmp++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL ready_after_edge: got %b want 1", cmd_ready); end
  endtask

  task automatic test_read;
    int n; logic [31:0] d; logic e; bit ok;
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, M_ACK, 1, n, d, e, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL read_done: timed out, want response"); end
    cmp++; if (cap_adr !== 32'h100 || cap_we !== 1'b0) begin
      errs++; $display("FAIL read_bus: adr=%h we=%b want 100/0", cap_adr, cap_we); end
    cmp++; if (n != 2) begin errs++; $display("FAIL read_latency: got %0d want 2", n); end
    cmp++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      errs++; $display("FAIL read_data: got %h/%b want deadbeef/0", d, e); end
    cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL read_after_hs: rv=%b rdy=%b busy=%b want 0/1/0", rsp_valid, cmd_ready, busy); end
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, M_ACK, 0, n, d, e, ok);
    cmp++; if (!ok || n != 1 || d !== 32'hDEADBEEF) begin
      errs++; $display("FAIL comb_ack_read: lat=%0d dat=%h want 1/deadbeef", n, d); end
  endtask

  task automatic test_write;
    int n; logic [31:0] d; logic e; bit ok;
    do_txn(1'b1, 32'h104, 32'h12345678, 4'hF, M_ACK, 1, n, d, e, ok);
    ref_mem[32'h104] = merge(ref_rd(32'h104), 32'h12345678, 4'hF);
    cmp++; if (!ok || cap_adr !== 32'h104 || cap_dat !== 32'h12345678 || cap_we !== 1'b1 || cap_sel !== 4'hF) begin
      errs++; $display("FAIL write_bus: adr=%h dat=%h we=%b sel=%h want 104/12345678/1/f",
                       cap_adr, cap_dat, cap_we, cap_sel); end
    cmp++; if (d !== 32'h0 || e !== 1'b0) begin
      errs++; $display("FAIL write_rsp: got %h/%b want 0/0", d, e); end
    cmp++; if (wb_we !== 1'b1 || wb_dato !== 32'h12345678 || wb_sel !== 4'hF) begin
      errs++; $display("FAIL write_hold: we=%b dat=%h sel=%h want last values", wb_we, wb_dato, wb_sel); end
  endtask

  task automatic test_backpressure;
    int w; logic [31:0] d0;
    @(negedge clk);
    s_mode = M_ACK; s_lat = 1;
    cmd_we = 1'b0; cmd_adr = 32'h100; cmd_sel = 4'hF; cmd_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_we = 1'b1; cmd_adr = 32'h108; cmd_dat = 32'hCAFEF00D; cmd_sel = 4'h3;
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    d0 = rsp_dat;
    cmp++; if (d0 !== 32'hDEADBEEF) begin errs++; $display("FAIL bp_data: got %h want deadbeef", d0); end
    for (int i = 0; i < 5; i++) begin
      cmp++;
      if (rsp_valid !== 1'b1 || rsp_dat !== d0 || cmd_ready !== 1'b0 || wb_cyc !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d: rv=%b dat=%h rdy=%b cyc=%b", i, rsp_valid, rsp_dat, cmd_ready, wb_cyc);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmp++; if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errs++; $display("FAIL bp_handshake: cyc=%b rdy=%b rv=%b want 0/1/0", wb_cyc, cmd_ready, rsp_valid); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmp++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h108 || wb_we !== 1'b1) begin
      errs++; $display("FAIL bp_queued: cyc=%b adr=%h we=%b want 1/108/1", wb_cyc, wb_adr, wb_we); end
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    ref_mem[32'h108] = merge(ref_rd(32'h108), 32'hCAFEF00D, 4'h3);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n; logic [31:0] d; logic e; bit ok;
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, M_NONE, 0, n, d, e, ok);
    cmp++; if (!ok || n != TO) begin errs++; $display("FAIL timeout_len: stb=%0d want %0d", n, TO); end
    cmp++; if (d !== 32'h0 || e !== 1'b1) begin errs++; $display("FAIL timeout_rsp: got %h/%b want 0/1", d, e); end
    do_txn(1'b0, 32'h104, 32'h0, 4'hF, M_ACK, 2, n, d, e, ok);
    cmp++; if (!ok || n != 3 || d !== ref_rd(32'h104) || e !== 1'b0) begin
      errs++; $display("FAIL after_timeout: lat=%0d dat=%h err=%b want 3/%h/0", n, d, e, ref_rd(32'h104)); end
  endtask

  task automatic test_err_priority;
    int n; logic [31:0] d; logic e; bit ok;
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, M_ERRACK, 1, n, d, e, ok);
    cmp++; if (!ok || d !== 32'h0 || e !== 1'b1) begin
      errs++; $display("FAIL err_priority: got %h/%b want 0/1", d, e); end
  endtask

  task automatic test_reset_mid;
    int w; int n; logic [31:0] d; logic e; bit ok;
    @(negedge clk);
    s_mode = M_NONE; cmd_we = 1'b0; cmd_adr = 32'h100; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp++; if (wb_cyc !== 1'b1) begin errs++; $display("FAIL mid_in_bus: cyc=%b want 1", wb_cyc); end
    rst = 1'b1;
    #1;
    cmp++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_abort: cyc=%b stb=%b rv=%b busy=%b want 0", wb_cyc, wb_stb, rsp_valid, busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_no_rsp: rv=%b want 0", rsp_valid); end
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, M_ACK, 1, n, d, e, ok);
    cmp++; if (!ok || d !== 32'hDEADBEEF || e !== 1'b0) begin
      errs++; $display("FAIL mid_reread: got %h/%b want deadbeef/0", d, e); end
  endtask

  task automatic test_random;
    int n, mode, lat, r; logic [31:0] a, dat, d, exp_d; logic [3:0] sel; logic we, e; bit ok;
    for (int i = 0; i < 30; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 32'h200 + 32'(4 * $urandom_range(0, 15));
      dat = $urandom;
      sel = 4'($urandom_range(1, 15));
      r   = $urandom_range(0, 9);
      mode = (r < 7) ? M_ACK : (r == 7) ? M_ERR : (r == 8) ? M_ERRACK : M_NONE;
      lat = $urandom_range(0, 3);
      exp_d = (!we && mode == M_ACK) ? ref_rd(a) : 32'h0;
      do_txn(we, a, dat, sel, mode, lat, n, d, e, ok);
      if (we && mode == M_ACK) ref_mem[a] = merge(ref_rd(a), dat, sel);
      cmp++;
      if (!ok || d !== exp_d || e !== (mode != M_ACK) || n != ((mode == M_NONE) ? TO : lat + 1)) begin
        errs++; $display("FAIL rand%0d: we=%b a=%h mode=%0d got %h/%b/%0d want %h/%b/%0d",
                         i, we, a, mode, d, e, n, exp_d, (mode != M_ACK), (mode == M_NONE) ? TO : lat + 1);
      end
      if (mode != M_NONE) begin
        cmp++;
        if (cap_adr !== a || cap_we !== we || cap_sel !== sel || (we && cap_dat !== dat)) begin
          errs++; $display("FAIL rand_bus%0d: adr=%h we=%b sel=%h dat=%h want %h/%b/%h/%h",
                           i, cap_adr, cap_we, cap_sel, cap_dat, a, we, sel, dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_timeout();
    test_err_priority();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

`default_nettype wire
